// File: rtl/test_result_reporter_pkg.sv
// Shared constants for the test result reporter: register offsets, verdict
// states, STATUS bit positions and the address-window helper.
package test_result_reporter_pkg;

  localparam logic [3:0] REG_TOHOST = 4'h0;
  localparam logic [3:0] REG_LOG    = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CYCLES = 4'hC;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_TMO     = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 24;

  // The register window is 16 bytes, so only the upper 28 bits select it.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/test_result_reporter_if.sv
// CPU-side MMIO port plus the LOG drain handshake of the test result reporter.
interface test_result_reporter_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, log_ready,
    input  rd_data, log_valid, log_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, log_ready,
    output rd_data, log_valid, log_data
  );
endinterface

// File: rtl/test_result_reporter_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head and a
// sticky overflow flag; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;
  logic             full, do_pop, do_push;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d    = ovf_q | (push && full && !do_pop);
    // Head tracks the word at the next read pointer, bypassing a write to that slot.
    if (count_d == '0)
      head_d = '0;
    else if (do_push && (wr_ptr_q == rd_ptr_d))
      head_d = push_data;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_data = head_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/test_result_reporter.sv
// MMIO result reporter: latches the program's TOHOST verdict, runs a watchdog
// and cycle counter, and buffers LOG words for an external consumer.
module test_result_reporter
  import test_result_reporter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WDOG_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   rst,
  test_result_reporter_if.slave  bus,
  output logic                   done,
  output logic                   pass,
  output logic [30:0]            fail_num,
  output logic                   timeout
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [30:0]        fail_num_q, fail_num_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [31:0]        cycles_q;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        status_w;
  logic               wr_hit, tohost_set, log_push, wdog_expire;
  logic               fifo_empty, fifo_ovf;
  logic [CNT_W-1:0]   fifo_count;

  assign wr_hit      = bus.wr_en && in_window(bus.wr_addr, BASE_ADDR);
  assign tohost_set  = wr_hit && (bus.wr_addr[3:0] == REG_TOHOST) && bus.wr_data[0];
  assign log_push    = wr_hit && (bus.wr_addr[3:0] == REG_LOG);
  // Any write into the window is a kick, so it always beats expiry.
  assign wdog_expire = (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) && !wr_hit;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (log_push),
    .pop       (bus.log_ready),
    .push_data (bus.wr_data),
    .head_data (bus.log_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  assign bus.log_valid = !fifo_empty;

  always_comb begin
    state_d    = state_q;
    fail_num_d = fail_num_q;
    wdog_d     = wdog_q;
    case (state_q)
      ST_RUN: begin
        wdog_d = wr_hit ? '0 : wdog_q + WDOG_W'(1);
        if (tohost_set) begin
          if (bus.wr_data == 32'h1) begin
            state_d = ST_PASS;
          end else begin
            state_d    = ST_FAIL;
            fail_num_d = bus.wr_data[31:1];
          end
        end else if (wdog_expire) begin
          state_d = ST_TMO;
        end
      end
      default: ;
    endcase
  end

  assign done     = (state_q != ST_RUN);
  assign pass     = (state_q == ST_PASS);
  assign timeout  = (state_q == ST_TMO);
  assign fail_num = fail_num_q;

  always_comb begin
    status_w                          = '0;
    status_w[STAT_DONE]               = done;
    status_w[STAT_PASS]               = pass;
    status_w[STAT_TMO]                = timeout;
    status_w[STAT_OVF]                = fifo_ovf;
    status_w[STAT_CNT_LSB +: 8]       = 8'(fifo_count);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      if (in_window(bus.rd_addr, BASE_ADDR)) begin
        case (bus.rd_addr[3:0])
          REG_STATUS: rd_data_d = status_w;
          REG_CYCLES: rd_data_d = cycles_q;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fail_num_q <= '0;
      wdog_q     <= '0;
      cycles_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      fail_num_q <= fail_num_d;
      wdog_q     <= wdog_d;
      cycles_q   <= cycles_q + 32'd1;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_test_result_reporter.sv
// Directed scenarios plus a randomized phase, every cycle compared against a
// queue-based reference model of the reporter's documented behaviour.
module tb_test_result_reporter;

  localparam logic [31:0] BASE  = 32'h8000_0100;
  localparam int          DEPTH = 8;
  localparam int          WDOG  = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done, pass, timeout;
  logic [30:0] fail_num;

  test_result_reporter_if bus();

  test_result_reporter #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .done     (done),
    .pass     (pass),
    .fail_num (fail_num),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic        m_done, m_pass, m_tmo, m_ovf;
  logic [30:0] m_fail;
  logic [31:0] m_cycles, m_rd;
  int          m_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_done = 0; m_pass = 0; m_tmo = 0; m_ovf = 0;
    m_fail = '0; m_cycles = '0; m_rd = '0; m_idle = 0;
  endtask

  // Advance one clock: update the model from the inputs seen at this edge,
  // then compare every DUT output with the model.
  task automatic step();
    logic        do_pop, was_full, hit;
    logic [31:0] status, woff, roff;
    if (rst) begin
      model_reset();
    end else begin
      status = {8'(m_q.size()), 20'b0, m_ovf, m_tmo, m_pass, m_done};
      roff   = bus.rd_addr - BASE;
      if (bus.rd_en) begin
        m_rd = '0;
        if (roff == 32'h8) m_rd = status;
        if (roff == 32'hC) m_rd = m_cycles;
      end
      woff     = bus.wr_addr - BASE;
      hit      = bus.wr_en && (woff < 32'd16);
      do_pop   = (m_q.size() != 0) && bus.log_ready;
      was_full = (m_q.size() == DEPTH);
      if (do_pop) void'(m_q.pop_front());
      if (hit && woff == 32'h4) begin
        if (!was_full || do_pop) m_q.push_back(bus.wr_data);
        else m_ovf = 1;
      end
      if (!m_done) begin
        if (hit && woff == 32'h0 && bus.wr_data[0]) begin
          m_done = 1;
          if (bus.wr_data == 32'h1) m_pass = 1;
          else m_fail = bus.wr_data[31:1];
        end else if (hit) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == WDOG) begin
            m_done = 1;
            m_tmo  = 1;
          end
        end
      end
      m_cycles = m_cycles + 32'd1;
    end
    @(posedge clk);
    #1;
    check("model_log_valid", 32'(bus.log_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("model_log_data", bus.log_data, m_q[0]);
    check("model_done", 32'(done), 32'(m_done));
    check("model_pass", 32'(pass), 32'(m_pass));
    check("model_timeout", 32'(timeout), 32'(m_tmo));
    check("model_fail_num", 32'(fail_num), 32'(m_fail));
    check("model_rd_data", bus.rd_data, m_rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    $display("write addr=%h data=%h", addr, data);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [31:0] addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    step();
    bus.rd_en = 1'b0;
    $display("read  addr=%h data=%h", addr, bus.rd_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] exp_drain[DEPTH];

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.log_ready = 0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_fail_num", 32'(fail_num), 32'd0);
    check("rst_log_valid", 32'(bus.log_valid), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);

    // Watchdog expires exactly 500 cycles after reset
    idle(WDOG - 1);
    check("wdog_499_no_tmo", 32'(timeout), 32'd0);
    idle(1);
    check("wdog_500_tmo", 32'(timeout), 32'd1);
    check("wdog_500_done", 32'(done), 32'd1);
    mmio_write(BASE + 32'h0, 32'h1);
    check("tmo_terminal_pass", 32'(pass), 32'd0);

    // A window write at cycle 499 counts as a kick
    do_reset();
    idle(WDOG - 1);
    mmio_write(BASE + 32'h8, 32'h0);
    check("kick_499_no_tmo", 32'(timeout), 32'd0);
    idle(WDOG - 1);
    check("kick_restart_no_tmo", 32'(timeout), 32'd0);
    idle(1);
    check("kick_restart_tmo", 32'(timeout), 32'd1);

    // PASS verdict and STATUS
    do_reset();
    mmio_write(BASE + 32'h0, 32'h6);
    check("tohost_bit0_clear_ignored", 32'(done), 32'd0);
    mmio_write(BASE + 32'h0, 32'h1);
    check("pass_done", 32'(done), 32'd1);
    check("pass_pass", 32'(pass), 32'd1);
    check("pass_fail_num", 32'(fail_num), 32'd0);
    mmio_read(BASE + 32'h8);
    check("pass_status", bus.rd_data, 32'h0000_0003);

    // FAIL verdict is terminal
    do_reset();
    mmio_write(BASE + 32'h0, 32'h7);
    check("fail_done", 32'(done), 32'd1);
    check("fail_pass", 32'(pass), 32'd0);
    check("fail_num_3", 32'(fail_num), 32'd3);
    mmio_write(BASE + 32'h0, 32'h1);
    check("fail_terminal_pass", 32'(pass), 32'd0);
    check("fail_terminal_num", 32'(fail_num), 32'd3);

    // Overflow: 9 pushes into 8 entries, then drain in order
    do_reset();
    for (int i = 1; i <= 9; i++) mmio_write(BASE + 32'h4, 32'(i));
    mmio_read(BASE + 32'h8);
    check("ovf_status", bus.rd_data, 32'h0800_0008);
    bus.log_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", 32'(bus.log_valid), 32'd1);
      check("drain_data", bus.log_data, 32'(i));
      step();
    end
    bus.log_ready = 1'b0;
    check("drain_empty", 32'(bus.log_valid), 32'd0);

    // Push into full FIFO with simultaneous pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) mmio_write(BASE + 32'h4, 32'h10 + 32'(i));
    bus.log_ready = 1'b1;
    mmio_write(BASE + 32'h4, 32'hAB);
    bus.log_ready = 1'b0;
    mmio_read(BASE + 32'h8);
    check("full_pushpop_status", bus.rd_data, 32'h0800_0000);
    for (int i = 0; i < DEPTH - 1; i++) exp_drain[i] = 32'h11 + 32'(i);
    exp_drain[DEPTH-1] = 32'hAB;
    bus.log_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("full_drain_data", bus.log_data, exp_drain[i]);
      step();
    end
    bus.log_ready = 1'b0;
    check("full_drain_empty", 32'(bus.log_valid), 32'd0);

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 5; i++) mmio_write(BASE + 32'h4, 32'h100 + 32'(i));
    mmio_write(BASE + 32'h0, 32'h1);
    bus.log_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.log_ready = 1'b0;
    check("midrst_log_valid", 32'(bus.log_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    mmio_read(BASE + 32'h8);
    check("midrst_status", bus.rd_data, 32'h0);
    mmio_read(BASE + 32'hC);
    check("midrst_cycles_small", 32'(bus.rd_data < 32'd4), 32'd1);

    // Unmapped reads return zero; rd_data holds without rd_en
    mmio_read(BASE + 32'h10);
    check("unmapped_read", bus.rd_data, 32'h0);
    mmio_read(BASE + 32'hC);
    idle(3);
    check("rd_hold_nonzero", 32'(bus.rd_data != 32'h0), 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = (sel < 4) ? BASE + 32'(sel * 4) : $urandom;
      if (sel == 0)
        bus.wr_data = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFE);
      else
        bus.wr_data = $urandom;
      bus.rd_en     = ($urandom_range(0, 1) == 0);
      bus.rd_addr   = ($urandom_range(0, 4) == 0) ? $urandom : BASE + 32'($urandom_range(0, 3) * 4);
      bus.log_ready = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 149) == 0);
      if (bus.wr_en) $display("rand  write addr=%h data=%h", bus.wr_addr, bus.wr_data);
      step();
    end
    bus.wr_en = 0; bus.rd_en = 0; bus.log_ready = 0; rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
